// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA display constants, RGB pixel type and index-to-colour helper
package vga_pkg;

  localparam int LINE_WIDTH   = 640;
  localparam int FRAME_ROWS   = 480;
  localparam int FB_ADDR_BITS = 19;
  localparam int RED_BITS     = 3;
  localparam int GREEN_BITS   = 3;
  localparam int BLUE_BITS    = 2;

  typedef struct packed {
    logic [RED_BITS-1:0]   red;
    logic [GREEN_BITS-1:0] green;
    logic [BLUE_BITS-1:0]  blue;
  } rgb_t;

  localparam rgb_t RGB_BLACK = '0;

  function automatic rgb_t rgb_from_index(input logic [7:0] i);
    rgb_t c;
    c.red   = i[2:0];
    c.green = i[5:3];
    c.blue  = i[7:6];
    return c;
  endfunction

endpackage

// File: rtl/iter_palette.sv
// rtl/iter_palette.sv - combinational iteration-count to RGB mapping; points inside the set are black
module iter_palette
  import vga_pkg::*;
#(
  parameter int ITER_BITS = 8,
  parameter int MAX_ITER  = 255
) (
  input  logic [ITER_BITS-1:0] iter,
  input  logic [ITER_BITS-1:0] offset,
  output rgb_t                 rgb
);

  logic [ITER_BITS-1:0] idx;

  // The inside-set test looks at the raw count so cycling never lights up the set itself.
  always_comb begin
    idx = iter + offset;
    rgb = (iter == ITER_BITS'(MAX_ITER)) ? RGB_BLACK : rgb_from_index(8'(idx));
  end

endmodule

// File: rtl/vga_pixel_pipe.sv
// rtl/vga_pixel_pipe.sv - framebuffer fetch, palette and sync alignment between vgatimer and VGA pins
// Optional per-frame palette cycling is enabled by defining VGA_PALETTE_CYCLE_EN.
module vga_pixel_pipe
  import vga_pkg::*;
#(
  parameter int XBITS       = 10,
  parameter int YBITS       = 10,
  parameter int ADDR_BITS   = 19,
  parameter int ITER_BITS   = 8,
  parameter int MAX_ITER    = 255,
  parameter int MEM_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 hsync_in,
  input  logic                 vsync_in,
  input  logic                 activevideo_in,
  input  logic [XBITS-1:0]     x,
  input  logic [YBITS-1:0]     y,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic                 mem_rd,
  input  logic [ITER_BITS-1:0] mem_data,
  output logic                 hsync,
  output logic                 vsync,
  output logic [2:0]           red,
  output logic [2:0]           green,
  output logic [1:0]           blue
);

  localparam int L = MEM_LATENCY + 2;

  logic [ADDR_BITS-1:0] row_base_q, row_base_d;
  logic [YBITS-1:0]     y_prev_q, y_prev_d;
  logic [ADDR_BITS-1:0] mem_addr_q, mem_addr_d;
  logic                 mem_rd_q, mem_rd_d;
  logic [L-1:0]         hsync_dly_q, hsync_dly_d;
  logic [L-1:0]         vsync_dly_q, vsync_dly_d;
  logic [L-2:0]         act_dly_q, act_dly_d;
  rgb_t                 rgb_q, rgb_d;
  rgb_t                 pal_rgb;
  logic [ITER_BITS-1:0] pal_offset;

`ifdef VGA_PALETTE_CYCLE_EN
  logic                 vsync_prev_q, vsync_prev_d;
  logic [ITER_BITS-1:0] offset_q, offset_d;

  always_comb begin
    vsync_prev_d = vsync_in;
    offset_d     = offset_q;
    if (vsync_prev_q && !vsync_in) begin
      offset_d = offset_q + ITER_BITS'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vsync_prev_q <= 1'b1;
      offset_q     <= '0;
    end else begin
      vsync_prev_q <= vsync_prev_d;
      offset_q     <= offset_d;
    end
  end

  assign pal_offset = offset_q;
`else
  assign pal_offset = '0;
`endif

  iter_palette #(
    .ITER_BITS (ITER_BITS),
    .MAX_ITER  (MAX_ITER)
  ) u_palette (
    .iter   (mem_data),
    .offset (pal_offset),
    .rgb    (pal_rgb)
  );

  // Row base is stepped by one line per y change; the updated value feeds the address in the same cycle.
  always_comb begin
    row_base_d = row_base_q;
    y_prev_d   = y_prev_q;
    if (y != y_prev_q) begin
      y_prev_d   = y;
      row_base_d = (y == '0) ? '0 : row_base_q + ADDR_BITS'(LINE_WIDTH);
    end
    mem_addr_d  = row_base_d + ADDR_BITS'(x);
    mem_rd_d    = activevideo_in;
    hsync_dly_d = {hsync_dly_q[L-2:0], hsync_in};
    vsync_dly_d = {vsync_dly_q[L-2:0], vsync_in};
    act_dly_d   = {act_dly_q[L-3:0], activevideo_in};
    rgb_d       = act_dly_q[L-2] ? pal_rgb : RGB_BLACK;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_base_q  <= '0;
      y_prev_q    <= '0;
      mem_addr_q  <= '0;
      mem_rd_q    <= 1'b0;
      hsync_dly_q <= '1;
      vsync_dly_q <= '1;
      act_dly_q   <= '0;
      rgb_q       <= RGB_BLACK;
    end else begin
      row_base_q  <= row_base_d;
      y_prev_q    <= y_prev_d;
      mem_addr_q  <= mem_addr_d;
      mem_rd_q    <= mem_rd_d;
      hsync_dly_q <= hsync_dly_d;
      vsync_dly_q <= vsync_dly_d;
      act_dly_q   <= act_dly_d;
      rgb_q       <= rgb_d;
    end
  end

  assign mem_addr = mem_addr_q;
  assign mem_rd   = mem_rd_q;
  assign hsync    = hsync_dly_q[L-1];
  assign vsync    = vsync_dly_q[L-1];
  assign red      = rgb_q.red;
  assign green    = rgb_q.green;
  assign blue     = rgb_q.blue;

endmodule
